load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, byte-address width of data memory; mem_addr is ADDR_BITS-2 wide.
REQ-002 SHALL have parameter TIMEOUT, default 63, max WAIT cycles before fault.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  MEM stage holds a load/store.
REQ-007 req_load  in  1  1=load, 0=store.
REQ-008 req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  32  byte address from ALU.
REQ-010 req_wdata  in  32  store data (rs2).
REQ-011 stall  out  1  freeze pipeline.
REQ-012 load_valid  out  1  one-cycle pulse, load_data valid.
REQ-013 load_data  out  32  extended load result, registered.
REQ-014 fault  out  1  one-cycle pulse, access aborted; fault_cause  out  2  01 misaligned, 10 illegal width, 11 timeout.
REQ-015 mem_addr  out  ADDR_BITS-2  word address = req_addr[ADDR_BITS-1:2].
REQ-016 mem_ren / mem_wen  out  1 each  read / write strobe, never both high.
REQ-017 mem_wdata  out  32  lane-replicated store data; mem_bsel  out  4  byte enables.
REQ-018 mem_rdata  in  32  read data; mem_ready  in  1  memory idle / read data valid.

Function
REQ-019 States SHALL be IDLE, WAIT, DONE.
REQ-020 IDLE, req_valid, width illegal (011,110,111, or store with 1xx): fault=1, cause 10, no strobe, stall=0, stay IDLE.
REQ-021 IDLE, misaligned (H/HU addr[0]=1; W addr[1:0]!=0): fault=1, cause 01, no strobe, stall=0, stay IDLE.
REQ-022 IDLE, valid legal request, mem_ready=0: stall=1, no strobe, stay IDLE.
REQ-023 IDLE, store, mem_ready=1: mem_wen=1 combinationally for that cycle only, stall=0, stay IDLE.
REQ-024 Store lanes: SB wdata={4{rs2[7:0]}}, bsel=0001<<addr[1:0]; SH wdata={2{rs2[15:0]}}, bsel=addr[1]?1100:0011; SW wdata=rs2, bsel=1111.
REQ-025 IDLE, load, mem_ready=1: mem_ren=1 for exactly one cycle, stall=1, latch funct3 and addr[1:0], clear timeout counter, go WAIT.
REQ-026 WAIT: mem_ren=0, stall=1; counter increments each cycle; on mem_ready=1 register extended mem_rdata into load_data, go DONE.
REQ-027 Load extract: shift mem_rdata right by 8*addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-028 WAIT with counter==TIMEOUT and mem_ready=0: go DONE with load_data=0, fault=1, cause 11, load_valid=0.
REQ-029 DONE: stall=0, load_valid=1 (unless timeout), one cycle; req_valid ignored; go IDLE unconditionally.
REQ-030 Load latency = 2 + memory wait cycles; store latency 0 stall cycles when mem_ready=1.
REQ-031 No address range check; out-of-range reads return whatever memory supplies (0).

Reset
REQ-032 Reset SHALL force IDLE, stall=0, load_valid=0, fault=0, fault_cause=00, load_data=0, counter=0, all mem strobes 0, mem_bsel=0.
REQ-033 Reset during WAIT SHALL abandon the read; the REQ-022 mem_ready gate prevents issue until memory returns to idle.

Structure
REQ-034 Shared package lsu_pkg SHALL hold funct3 width codes, fault_cause codes, state encoding.
REQ-035 Combinational sub-module lsu_align SHALL implement store lane mapping and load extraction; FSM and counter stay in top.

Verification
REQ-036 SW addr 0x8, rs2 0xDEADBEEF -> same cycle mem_wen=1, mem_addr=2, bsel=1111, wdata 0xDEADBEEF, stall=0.
REQ-037 SB addr 0x7, rs2 0x000000A5 -> bsel=1000, wdata 0xA5A5A5A5.
REQ-038 LB addr 0x5, mem word 0x0000F000, ready after 7 cycles -> stall high until DONE, load_valid pulse, load_data 0xFFFFFFF0; LBU -> 0x000000F0.
REQ-039 LW addr 0x6 -> fault=1 cause 01, no strobe; funct3 011 -> cause 10.
REQ-040 mem_ready held 0 after issue -> at counter 63 fault cause 11, load_data 0, back to IDLE.
REQ-041 Reset asserted in WAIT while memory busy -> IDLE outputs zero; next LW stalls until mem_ready=1 then issues once.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, fault causes,
// FSM encoding and the store-lane payload.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BSEL_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_WIDTH    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   wdata;
        logic [BSEL_W-1:0] bsel;
    } store_lane_t;

    // Unsigned widths only exist for loads.
    function automatic logic width_legal(input logic [2:0] f3, input logic is_load);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return is_load;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        case (f3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication/byte enables and load
// extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_offset,
    input  logic [XLEN-1:0] st_data,
    output store_lane_t     st_lane_c,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    input  logic [XLEN-1:0] ld_word,
    output logic [XLEN-1:0] ld_data_c
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        st_lane_c = '0;
        case (st_funct3[1:0])
            2'b00: begin
                st_lane_c.wdata = {4{st_data[7:0]}};
                st_lane_c.bsel  = 4'b0001 << st_offset;
            end
            2'b01: begin
                st_lane_c.wdata = {2{st_data[15:0]}};
                st_lane_c.bsel  = st_offset[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_lane_c.wdata = st_data;
                st_lane_c.bsel  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        shifted   = ld_word >> {ld_offset, 3'b000};
        ld_data_c = shifted;
        case (ld_funct3)
            F3_B:    ld_data_c = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data_c = {24'b0, shifted[7:0]};
            F3_H:    ld_data_c = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data_c = {16'b0, shifted[15:0]};
            default: ld_data_c = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: validates the access, drives the data memory
// strobes and stalls the pipeline while a load is outstanding.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned TIMEOUT   = 63
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_load,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 stall,
    output logic                 load_valid,
    output logic [31:0]          load_data,
    output logic                 fault,
    output logic [1:0]           fault_cause,
    output logic [ADDR_BITS-3:0] mem_addr,
    output logic                 mem_ren,
    output logic                 mem_wen,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_bsel,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       lat_funct3, lat_funct3_nxt;
    logic [1:0]       lat_offset, lat_offset_nxt;
    logic [31:0]      load_data_nxt;
    logic             timed_out, timed_out_nxt;

    store_lane_t      st_lane;
    logic [31:0]      ld_ext;

    lsu_align u_align (
        .st_funct3 (req_funct3),
        .st_offset (req_addr[1:0]),
        .st_data   (req_wdata),
        .st_lane_c (st_lane),
        .ld_funct3 (lat_funct3),
        .ld_offset (lat_offset),
        .ld_word   (mem_rdata),
        .ld_data_c (ld_ext)
    );

    assign mem_addr  = req_addr[ADDR_BITS-1:2];
    assign mem_wdata = st_lane.wdata;

    // Address bits above the memory window are deliberately ignored.
    if (ADDR_BITS < 32) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr[31:ADDR_BITS];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lat_funct3 <= '0;
            lat_offset <= '0;
            load_data  <= '0;
            timed_out  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            lat_funct3 <= lat_funct3_nxt;
            lat_offset <= lat_offset_nxt;
            load_data  <= load_data_nxt;
            timed_out  <= timed_out_nxt;
        end
    end

    // Outputs are held at zero while reset is asserted.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        lat_funct3_nxt = lat_funct3;
        lat_offset_nxt = lat_offset;
        load_data_nxt  = load_data;
        timed_out_nxt  = timed_out;
        stall          = 1'b0;
        load_valid     = 1'b0;
        fault          = 1'b0;
        fault_cause    = CAUSE_NONE;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;
        mem_bsel       = 4'b0000;

        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (!width_legal(req_funct3, req_load)) begin
                            fault       = 1'b1;
                            fault_cause = CAUSE_WIDTH;
                        end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
                            fault       = 1'b1;
                            fault_cause = CAUSE_MISALIGN;
                        end else if (!mem_ready) begin
                            stall = 1'b1;
                        end else if (!req_load) begin
                            mem_wen  = 1'b1;
                            mem_bsel = st_lane.bsel;
                        end else begin
                            mem_ren        = 1'b1;
                            stall          = 1'b1;
                            lat_funct3_nxt = req_funct3;
                            lat_offset_nxt = req_addr[1:0];
                            cnt_nxt        = '0;
                            state_nxt      = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    stall   = 1'b1;
                    cnt_nxt = CNT_W'(cnt + 1'b1);
                    if (mem_ready) begin
                        load_data_nxt = ld_ext;
                        timed_out_nxt = 1'b0;
                        state_nxt     = ST_DONE;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        load_data_nxt = '0;
                        timed_out_nxt = 1'b1;
                        state_nxt     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (timed_out) begin
                        fault       = 1'b1;
                        fault_cause = CAUSE_TIMEOUT;
                    end else begin
                        load_valid = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level reference
// model, behavioural data memory with programmable wait states.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_load;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [7:0]  mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bsel;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    load_store_unit #(.ADDR_BITS(10), .TIMEOUT(63)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_load(req_load),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_valid(load_valid), .load_data(load_data),
        .fault(fault), .fault_cause(fault_cause), .mem_addr(mem_addr),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_bsel(mem_bsel), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ren_count = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural data memory ----------------
    logic [31:0] mem [0:255];
    int unsigned mem_lat = 0;
    bit          mem_force_busy = 1'b0;
    bit          mem_pending = 1'b0;
    int unsigned mem_cnt = 0;
    logic [7:0]  mem_rd_addr = 8'h00;

    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    assign mem_ready = !mem_force_busy && (!mem_pending || mem_cnt == 0);
    assign mem_rdata = mem[mem_rd_addr];

    always @(posedge clk) begin
        if (mem_ren) begin
            mem_pending <= 1'b1;
            mem_cnt     <= mem_lat;
            mem_rd_addr <= mem_addr;
        end else if (mem_pending) begin
            if (mem_ready) mem_pending <= 1'b0;
            else if (mem_cnt != 0) mem_cnt <= mem_cnt - 1;
        end
        if (mem_wen)
            for (int i = 0; i < 4; i++)
                if (mem_bsel[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [31:0] v;
        int b;
        v = word >> (8 * off);
        case (f3)
            3'b000: begin b = int'(v % 256);   return (b >= 128)   ? 32'(b - 256)   : 32'(b); end
            3'b001: begin b = int'(v % 65536); return (b >= 32768) ? 32'(b - 65536) : 32'(b); end
            3'b100: return v % 256;
            3'b101: return v % 65536;
            default: return v;
        endcase
    endfunction

    function automatic logic [3:0] model_bsel(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'(1 << off);
            2'b01:   return 4'(3 << (off & 2'b10));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return (wd % 256) * 32'h01010101;
            2'b01:   return (wd % 65536) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    typedef struct packed {logic flt; logic [1:0] cause; logic [31:0] data;} res_t;
    typedef struct packed {logic [7:0] addr; logic [3:0] bsel; logic [31:0] wdata;} st_t;
    typedef struct packed {
        logic wen; logic [7:0] addr; logic [3:0] bsel; logic [31:0] wdata;
        logic lv; logic [31:0] data; logic flt; logic [1:0] cause;
    } snap_t;

    res_t res_q[$];
    st_t  st_q[$];
    res_t cmp_res;
    st_t  cmp_st;

    // Per-cycle comparison of strobes and result events against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_ren) ren_count++;
            if (mem_ren || mem_wen) chk("ren_wen_exclusive", 32'(mem_ren & mem_wen), 32'd0);
            if (mem_wen) begin
                if (st_q.size() == 0) begin
                    chk("unexpected_store", 32'd1, 32'd0);
                end else begin
                    cmp_st = st_q.pop_front();
                    chk("store_addr", 32'(mem_addr), 32'(cmp_st.addr));
                    chk("store_bsel", 32'(mem_bsel), 32'(cmp_st.bsel));
                    chk("store_wdata", mem_wdata, cmp_st.wdata);
                    chk("store_stall", 32'(stall), 32'd0);
                end
            end
            if (load_valid || fault) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    cmp_res = res_q.pop_front();
                    chk("res_fault", 32'(fault), 32'(cmp_res.flt));
                    chk("res_cause", 32'(fault_cause), 32'(cmp_res.cause));
                    chk("res_load_valid", 32'(load_valid), 32'(!cmp_res.flt));
                    chk("res_stall", 32'(stall), 32'd0);
                    if (!cmp_res.flt || cmp_res.cause == 2'b11)
                        chk("res_load_data", load_data, cmp_res.data);
                end
            end
        end
    end

    // Present one request, hold it while stalled, return stall count and
    // a snapshot of the outputs in the first non-stalled cycle.
    task automatic do_req(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit exp_to,
                          output int sc, output snap_t sn);
        int  ren0;
        bit  legal, mis, done;
        legal = (f3 <= 3'd2) || (ld && (f3 == 3'd4 || f3 == 3'd5));
        mis   = legal && ((addr % (1 << f3[1:0])) != 0);
        if (!legal)      res_q.push_back(res_t'{1'b1, 2'b10, 32'h0});
        else if (mis)    res_q.push_back(res_t'{1'b1, 2'b01, 32'h0});
        else if (!ld)    st_q.push_back(st_t'{addr[9:2], model_bsel(f3, addr[1:0]), model_wdata(f3, wd)});
        else if (exp_to) res_q.push_back(res_t'{1'b1, 2'b11, 32'h0});
        else             res_q.push_back(res_t'{1'b0, 2'b00, model_load(f3, addr[1:0], mem[addr[9:2]])});
        ren0 = ren_count;
        sn   = '0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        sc = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (stall) sc++;
            else begin
                done = 1'b1;
                sn = '{mem_wen, mem_addr, mem_bsel, mem_wdata, load_valid, load_data, fault, fault_cause};
            end
        end
        if (!done) chk("req_completes", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ren_pulses", 32'(ren_count - ren0), (legal && !mis && ld) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        snap_t sn;
        int    sc;

        // Reset with a legal store presented: everything must stay quiet.
        reset = 1'b1; req_valid = 1'b1; req_load = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h8; req_wdata = 32'h1;
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cause", 32'(fault_cause), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_ren", 32'(mem_ren), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_bsel", 32'(mem_bsel), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;

        // Pin the model to hand-computed values.
        chk("model_lb", model_load(3'b000, 2'd1, 32'h0000F000), 32'hFFFFFFF0);
        chk("model_lbu", model_load(3'b100, 2'd1, 32'h0000F000), 32'h000000F0);
        chk("model_sb_wdata", model_wdata(3'b000, 32'h000000A5), 32'hA5A5A5A5);
        chk("model_sh_bsel", 32'(model_bsel(3'b001, 2'd2)), 32'hC);

        // Stores
        do_req(1'b0, 3'b010, 32'h8, 32'hDEADBEEF, 1'b0, sc, sn);
        chk("sw_wen", 32'(sn.wen), 32'd1);
        chk("sw_addr", 32'(sn.addr), 32'd2);
        chk("sw_bsel", 32'(sn.bsel), 32'hF);
        chk("sw_wdata", sn.wdata, 32'hDEADBEEF);
        chk("sw_stall_cycles", 32'(sc), 32'd0);
        do_req(1'b0, 3'b000, 32'h7, 32'h000000A5, 1'b0, sc, sn);
        chk("sb_bsel", 32'(sn.bsel), 32'h8);
        chk("sb_wdata", sn.wdata, 32'hA5A5A5A5);
        do_req(1'b0, 3'b001, 32'h2, 32'h1234ABCD, 1'b0, sc, sn);
        chk("sh_bsel", 32'(sn.bsel), 32'hC);
        do_req(1'b0, 3'b010, 32'h4, 32'h0000F000, 1'b0, sc, sn);
        do_req(1'b0, 3'b010, 32'h24, 32'h80001234, 1'b0, sc, sn);

        // Loads with 7 memory wait cycles
        mem_lat = 7;
        do_req(1'b1, 3'b000, 32'h5, 32'h0, 1'b0, sc, sn);
        chk("lb_stall_cycles", 32'(sc), 32'd9);
        chk("lb_load_valid", 32'(sn.lv), 32'd1);
        chk("lb_data", sn.data, 32'hFFFFFFF0);
        do_req(1'b1, 3'b100, 32'h5, 32'h0, 1'b0, sc, sn);
        chk("lbu_data", sn.data, 32'h000000F0);

        // Loads with zero wait cycles
        mem_lat = 0;
        do_req(1'b1, 3'b010, 32'h8, 32'h0, 1'b0, sc, sn);
        chk("lw_stall_cycles", 32'(sc), 32'd2);
        chk("lw_data", sn.data, 32'hDEADBEEF);
        do_req(1'b1, 3'b001, 32'h2, 32'h0, 1'b0, sc, sn);
        chk("lh_data", sn.data, 32'hFFFFABCD);
        do_req(1'b1, 3'b101, 32'h2, 32'h0, 1'b0, sc, sn);
        do_req(1'b1, 3'b000, 32'h8, 32'h0, 1'b0, sc, sn);

        // Faults
        do_req(1'b1, 3'b010, 32'h6, 32'h0, 1'b0, sc, sn);
        chk("lw_mis_fault", 32'(sn.flt), 32'd1);
        chk("lw_mis_cause", 32'(sn.cause), 32'd1);
        chk("lw_mis_wen", 32'(sn.wen), 32'd0);
        do_req(1'b1, 3'b011, 32'h8, 32'h0, 1'b0, sc, sn);
        chk("f3_011_cause", 32'(sn.cause), 32'd2);
        do_req(1'b1, 3'b001, 32'h3, 32'h0, 1'b0, sc, sn);
        do_req(1'b0, 3'b100, 32'h4, 32'h55, 1'b0, sc, sn);
        do_req(1'b0, 3'b001, 32'h1, 32'h55, 1'b0, sc, sn);
        do_req(1'b1, 3'b110, 32'h0, 32'h0, 1'b0, sc, sn);

        do_req(1'b1, 3'b100, 32'hB, 32'h0, 1'b0, sc, sn);
        chk("lbu_hi_data", sn.data, 32'h000000DE);

        // Reset while a read is outstanding and memory stays busy.
        @(posedge clk); #1;
        req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h24;
        @(posedge clk); #2;
        mem_force_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("wrst_stall", 32'(stall), 32'd0);
        chk("wrst_ren", 32'(mem_ren), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("wrst_idle_stall", 32'(stall), 32'd0);
        chk("wrst_load_valid", 32'(load_valid), 32'd0);
        chk("wrst_fault", 32'(fault), 32'd0);
        chk("wrst_load_data", load_data, 32'd0);

        // Next load waits for memory to go idle, then issues once.
        fork
            do_req(1'b1, 3'b010, 32'h24, 32'h0, 1'b0, sc, sn);
            begin repeat (4) @(posedge clk); #2 mem_force_busy = 1'b0; end
        join
        chk("busy_stall_cycles", 32'(sc), 32'd5);
        chk("busy_data", sn.data, 32'h80001234);

        // Memory never answers after issue: timeout.
        fork
            do_req(1'b1, 3'b010, 32'h8, 32'h0, 1'b1, sc, sn);
            begin @(posedge clk); @(posedge clk); #2 mem_force_busy = 1'b1; end
        join
        chk("to_stall_cycles", 32'(sc), 32'd65);
        chk("to_fault", 32'(sn.flt), 32'd1);
        chk("to_cause", 32'(sn.cause), 32'd3);
        chk("to_load_data", sn.data, 32'd0);
        chk("to_load_valid", 32'(sn.lv), 32'd0);

        // Recovery after timeout
        mem_force_busy = 1'b0;
        mem_lat = 2;
        do_req(1'b1, 3'b001, 32'h26, 32'h0, 1'b0, sc, sn);
        chk("rec_stall_cycles", 32'(sc), 32'd4);
        chk("rec_data", sn.data, 32'hFFFF8000);

        repeat (2) @(negedge clk);
        chk("store_queue_drained", 32'(st_q.size()), 32'd0);
        chk("result_queue_drained", 32'(res_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
